// File: rtl/pool2x2_stream.sv
// Streaming 2x2 stride-2 pooling (max or floor-average) over raster-order pixels
// with all channels packed in one word; one pooled pixel per completed window.
module pool2x2_stream #(
  parameter int DATA_WIDHT = 32,
  parameter int CHANNEL    = 32,
  parameter int IMG_WIDHT  = 44,
  parameter int IMG_HEIGHT = 44,
  parameter int MODE       = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDHT*CHANNEL-1:0] Data_In,
  input  logic                          Valid_In,
  output logic [DATA_WIDHT*CHANNEL-1:0] Data_Out,
  output logic                          Valid_Out,
  output logic                          Frame_Done
);
  localparam int DW       = DATA_WIDHT;
  localparam int PW       = DATA_WIDHT * CHANNEL;
  localparam int HW       = DATA_WIDHT + 1;
  localparam int LB_DEPTH = IMG_WIDHT / 2;
  localparam int CW       = $clog2(IMG_WIDHT);
  localparam int RW       = $clog2(IMG_HEIGHT);
  localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam bit W_ODD    = (IMG_WIDHT % 2) == 1;
  localparam bit H_ODD    = (IMG_HEIGHT % 2) == 1;

  typedef enum logic [1:0] {EVEN_ROW = 2'd0, ODD_ROW = 2'd1, SKIP_ROW = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  logic [PW-1:0]       pair_q, pair_d;
  logic [PW-1:0]       data_out_q, data_out_d;
  logic                valid_out_q, valid_out_d;
  logic                frame_done_q, frame_done_d;
  logic [CHANNEL*HW-1:0] lb_mem_q [LB_DEPTH];

  logic                  last_col, last_row, odd_col, skip_next, pair_load, lb_we;
  logic [AW-1:0]         lb_addr;
  logic [CHANNEL*HW-1:0] lb_rd, hred_flat;
  logic [PW-1:0]         vred_flat;

  // Horizontal step: the sum keeps one extra bit so it can never overflow.
  function automatic logic [HW-1:0] hreduce(input logic signed [DW-1:0] a,
                                            input logic signed [DW-1:0] b);
    if (MODE == 0) hreduce = (a > b) ? {a[DW-1], a} : {b[DW-1], b};
    else           hreduce = {a[DW-1], a} + {b[DW-1], b};
  endfunction

  // Vertical step: the average is a 4-term sum shifted right by two (floor).
  function automatic logic [DW-1:0] vreduce(input logic signed [HW-1:0] top,
                                            input logic signed [HW-1:0] bot);
    logic [HW:0] s;
    s = '0;
    if (MODE == 0) begin
      vreduce = (top > bot) ? top[DW-1:0] : bot[DW-1:0];
    end else begin
      s       = {top[HW-1], top} + {bot[HW-1], bot};
      vreduce = s[DW+1:2];
    end
  endfunction

  assign last_col  = (col_q == CW'(IMG_WIDHT - 1));
  assign last_row  = (row_q == RW'(IMG_HEIGHT - 1));
  assign odd_col   = col_q[0];
  assign skip_next = H_ODD && (row_q == RW'(IMG_HEIGHT - 2));
  assign pair_load = !odd_col && !(W_ODD && last_col);
  assign lb_addr   = AW'(col_q >> 1);
  assign lb_rd     = lb_mem_q[lb_addr];

  always_comb begin
    hred_flat = '0;
    vred_flat = '0;
    for (int k = 0; k < CHANNEL; k++) begin
      hred_flat[k*HW +: HW] = hreduce(pair_q[k*DW +: DW], Data_In[k*DW +: DW]);
      vred_flat[k*DW +: DW] = vreduce(lb_rd[k*HW +: HW], hred_flat[k*HW +: HW]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= EVEN_ROW;
      col_q        <= '0;
      row_q        <= '0;
      pair_q       <= '0;
      data_out_q   <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      pair_q       <= pair_d;
      data_out_q   <= data_out_d;
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (lb_we) lb_mem_q[lb_addr] <= hred_flat;
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    if (Valid_In) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
        case (state_q)
          EVEN_ROW: state_d = ODD_ROW;
          ODD_ROW:  state_d = skip_next ? SKIP_ROW : EVEN_ROW;
          SKIP_ROW: state_d = EVEN_ROW;
          default:  state_d = EVEN_ROW;
        endcase
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    pair_d       = pair_q;
    lb_we        = 1'b0;
    data_out_d   = data_out_q;
    valid_out_d  = 1'b0;
    frame_done_d = 1'b0;
    if (Valid_In) begin
      if (pair_load) pair_d = Data_In;
      if (odd_col && state_q == EVEN_ROW) lb_we = 1'b1;
      if (odd_col && state_q == ODD_ROW) begin
        data_out_d  = vred_flat;
        valid_out_d = 1'b1;
      end
      frame_done_d = last_col && last_row;
    end
  end

  assign Data_Out   = data_out_q;
  assign Valid_Out  = valid_out_q;
  assign Frame_Done = frame_done_q;
endmodule

// File: tb/tb_pool2x2_stream.sv
// Bench for pool2x2_stream: 4x4 max and average instances share one stream,
// a 5x5 max instance gets its own; outputs are checked every cycle.
module tb_pool2x2_stream;
  localparam int DW = 32;
  localparam int CH = 2;
  localparam int PW = DW * CH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [PW-1:0] din44, din55;
  logic          vin44, vin55;
  logic [PW-1:0] dout_max44, dout_avg44, dout_max55;
  logic          vout_max44, vout_avg44, vout_max55;
  logic          fd_max44, fd_avg44, fd_max55;

  pool2x2_stream #(.DATA_WIDHT(DW), .CHANNEL(CH), .IMG_WIDHT(4), .IMG_HEIGHT(4), .MODE(0)) u_max44 (
    .clk(clk), .rst(rst), .Data_In(din44), .Valid_In(vin44),
    .Data_Out(dout_max44), .Valid_Out(vout_max44), .Frame_Done(fd_max44));
  pool2x2_stream #(.DATA_WIDHT(DW), .CHANNEL(CH), .IMG_WIDHT(4), .IMG_HEIGHT(4), .MODE(1)) u_avg44 (
    .clk(clk), .rst(rst), .Data_In(din44), .Valid_In(vin44),
    .Data_Out(dout_avg44), .Valid_Out(vout_avg44), .Frame_Done(fd_avg44));
  pool2x2_stream #(.DATA_WIDHT(DW), .CHANNEL(CH), .IMG_WIDHT(5), .IMG_HEIGHT(5), .MODE(0)) u_max55 (
    .clk(clk), .rst(rst), .Data_In(din55), .Valid_In(vin55),
    .Data_Out(dout_max55), .Valid_Out(vout_max55), .Frame_Done(fd_max55));

  typedef struct {
    logic [PW-1:0] pix;
    bit            ev;
    logic [PW-1:0] emax;
    logic [PW-1:0] eavg;
    bit            efd;
  } vec_t;
  vec_t vt[16];

  int total = 0;
  int bad   = 0;

  // Reference model: whole-frame images, window reduced from four stored pixels.
  logic [PW-1:0] img[2][5][5];
  int            nb[2];
  logic [PW-1:0] exp_max44_q[$], exp_avg44_q[$], exp_max55_q[$];
  logic [PW-1:0] hold_max44, hold_avg44, hold_max55;

  function automatic logic [PW-1:0] pool4(input logic [PW-1:0] p0, input logic [PW-1:0] p1,
                                          input logic [PW-1:0] p2, input logic [PW-1:0] p3,
                                          input bit avg);
    longint v[4];
    longint best, sum;
    logic [PW-1:0] res;
    res = '0;
    for (int k = 0; k < CH; k++) begin
      v[0] = longint'($signed(p0[k*DW +: DW]));
      v[1] = longint'($signed(p1[k*DW +: DW]));
      v[2] = longint'($signed(p2[k*DW +: DW]));
      v[3] = longint'($signed(p3[k*DW +: DW]));
      best = v[0];
      sum  = 0;
      for (int j = 0; j < 4; j++) begin
        if (v[j] > best) best = v[j];
        sum += v[j];
      end
      if (avg) best = sum >>> 2;
      res[k*DW +: DW] = best[DW-1:0];
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] rand_pix();
    logic [PW-1:0] p;
    for (int k = 0; k < CH; k++) begin
      case ($urandom_range(0, 5))
        0:       p[k*DW +: DW] = 32'h7FFF_FFFF;
        1:       p[k*DW +: DW] = 32'h8000_0000;
        default: p[k*DW +: DW] = $urandom();
      endcase
    end
    return p;
  endfunction

  task automatic model_beat(input int g, input int w, input int h, input logic [PW-1:0] pix,
                            output bit win, output logic [PW-1:0] mx, output logic [PW-1:0] av,
                            output bit fd);
    int r, c;
    r = nb[g] / w;
    c = nb[g] % w;
    img[g][r][c] = pix;
    win = (r % 2 == 1) && (c % 2 == 1);
    mx  = '0;
    av  = '0;
    if (win) begin
      mx = pool4(img[g][r-1][c-1], img[g][r-1][c], img[g][r][c-1], pix, 1'b0);
      av = pool4(img[g][r-1][c-1], img[g][r-1][c], img[g][r][c-1], pix, 1'b1);
    end
    fd    = (nb[g] == w * h - 1);
    nb[g] = (nb[g] + 1) % (w * h);
  endtask

  task automatic check_out(input string nm, input logic dv, input logic [PW-1:0] dd, input logic dfd,
                           input logic ev, input logic [PW-1:0] ed, input logic efd);
    total++;
    if (dv !== ev) begin
      bad++;
      $display("FAIL %s valid got=%0b exp=%0b t=%0t", nm, dv, ev, $time);
    end
    total++;
    if (dd !== ed) begin
      bad++;
      $display("FAIL %s data got=%h exp=%h t=%0t", nm, dd, ed, $time);
    end
    total++;
    if (dfd !== efd) begin
      bad++;
      $display("FAIL %s frame_done got=%0b exp=%0b t=%0t", nm, dfd, efd, $time);
    end
  endtask

  // One clock: drive at negedge, model the beats, check at the next negedge.
  task automatic cycle(input bit v_a, input logic [PW-1:0] p_a, input bit v_b, input logic [PW-1:0] p_b);
    bit win_a, fd_a, win_b, fd_b;
    logic [PW-1:0] mx_a, av_a, mx_b, av_b;
    win_a = 0; fd_a = 0; win_b = 0; fd_b = 0;
    vin44 = v_a; din44 = p_a;
    vin55 = v_b; din55 = p_b;
    if (v_a) begin
      model_beat(0, 4, 4, p_a, win_a, mx_a, av_a, fd_a);
      if (win_a) begin
        exp_max44_q.push_back(mx_a);
        exp_avg44_q.push_back(av_a);
      end
    end
    if (v_b) begin
      model_beat(1, 5, 5, p_b, win_b, mx_b, av_b, fd_b);
      if (win_b) exp_max55_q.push_back(mx_b);
    end
    @(negedge clk);
    if (win_a) begin
      hold_max44 = exp_max44_q.pop_front();
      hold_avg44 = exp_avg44_q.pop_front();
    end
    if (win_b) hold_max55 = exp_max55_q.pop_front();
    check_out("max44", vout_max44, dout_max44, fd_max44, win_a, hold_max44, fd_a);
    check_out("avg44", vout_avg44, dout_avg44, fd_avg44, win_a, hold_avg44, fd_a);
    check_out("max55", vout_max55, dout_max55, fd_max55, win_b, hold_max55, fd_b);
  endtask

  task automatic check_reset_state(input string nm);
    check_out({nm, "_max44"}, vout_max44, dout_max44, fd_max44, 1'b0, '0, 1'b0);
    check_out({nm, "_avg44"}, vout_avg44, dout_avg44, fd_avg44, 1'b0, '0, 1'b0);
    check_out({nm, "_max55"}, vout_max55, dout_max55, fd_max55, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset(input int cyc);
    rst   = 1'b0;
    vin44 = 1'b0;
    vin55 = 1'b0;
    #1;
    check_reset_state("rst_assert");
    repeat (cyc) @(negedge clk);
    check_reset_state("rst_hold");
    rst = 1'b1;
    nb[0] = 0;
    nb[1] = 0;
    hold_max44 = '0;
    hold_avg44 = '0;
    hold_max55 = '0;
    exp_max44_q.delete();
    exp_avg44_q.delete();
    exp_max55_q.delete();
  endtask

  function automatic logic [PW-1:0] ramp(input int x);
    return {-x, x};
  endfunction

  initial begin
    logic [PW-1:0] hmax, havg;
    rst = 1'b0; vin44 = 1'b0; vin55 = 1'b0; din44 = '0; din55 = '0;
    nb[0] = 0; nb[1] = 0;
    hold_max44 = '0; hold_avg44 = '0; hold_max55 = '0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b1;

    // Directed 4x4 ramp with hand-derived max and floor-average results.
    for (int i = 0; i < 16; i++) begin
      vt[i].pix  = ramp(i);
      vt[i].ev   = 1'b0;
      vt[i].emax = '0;
      vt[i].eavg = '0;
      vt[i].efd  = (i == 15);
    end
    vt[5].ev  = 1; vt[5].emax  = {32'h0000_0000, 32'h0000_0005}; vt[5].eavg  = {32'hFFFF_FFFD, 32'h0000_0002};
    vt[7].ev  = 1; vt[7].emax  = {32'hFFFF_FFFE, 32'h0000_0007}; vt[7].eavg  = {32'hFFFF_FFFB, 32'h0000_0004};
    vt[13].ev = 1; vt[13].emax = {32'hFFFF_FFF8, 32'h0000_000D}; vt[13].eavg = {32'hFFFF_FFF5, 32'h0000_000A};
    vt[15].ev = 1; vt[15].emax = {32'hFFFF_FFF6, 32'h0000_000F}; vt[15].eavg = {32'hFFFF_FFF3, 32'h0000_000C};

    hmax = '0;
    havg = '0;
    for (int i = 0; i < 16; i++) begin
      vin44 = 1'b1;
      din44 = vt[i].pix;
      vin55 = 1'b0;
      @(negedge clk);
      if (vt[i].ev) begin
        hmax = vt[i].emax;
        havg = vt[i].eavg;
      end
      check_out("tbl_max", vout_max44, dout_max44, fd_max44, vt[i].ev, hmax, vt[i].efd);
      check_out("tbl_avg", vout_avg44, dout_avg44, fd_avg44, vt[i].ev, havg, vt[i].efd);
    end
    hold_max44 = hmax;
    hold_avg44 = havg;
    cycle(1'b0, '0, 1'b0, '0);

    // 5x5 frame: last column and last row produce nothing.
    for (int i = 0; i < 25; i++) cycle(1'b0, '0, 1'b1, {32'(i * 7 - 40), 32'((i / 5) * 5 + i % 5)});
    cycle(1'b0, '0, 1'b0, '0);

    // 4x4 with a 3-cycle gap after every second beat.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, ramp(i), 1'b0, '0);
      if (i % 2 == 1) repeat (3) cycle(1'b0, $urandom(), 1'b0, '0);
    end

    // Two frames back to back, the second offset by 100.
    for (int i = 0; i < 32; i++) cycle(1'b1, ramp((i < 16) ? i : i - 16 + 100), 1'b0, '0);

    // Reset in the middle of a frame, then a clean frame.
    for (int i = 0; i < 7; i++) cycle(1'b1, ramp(50 - i), 1'b1, ramp(i * 3));
    do_reset(3);
    for (int i = 0; i < 16; i++) cycle(1'b1, ramp(i), 1'b0, '0);

    // Randomized stream with random gaps on both image sizes.
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) != 0, rand_pix(), $urandom_range(0, 3) != 0, rand_pix());
    repeat (2) cycle(1'b0, '0, 1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pool2x2_stream.md
Name: pool2x2_stream

Overview:
- Parametrised streaming 2x2, stride-2 pooling layer.
- Sits between conv layers of the CNN pipeline and uses the same Data_In/Valid_In -> Data_Out/Valid_Out streaming convention as the LayerN blocks.
- Accepts one pixel per valid beat, in raster order, with all channels packed in one word. Emits one pooled pixel per 2x2 window.
- MODE selects max or floor-average pooling; channel count and image size are generic.

Parameters:
- DATA_WIDHT, 32, width of one channel value, two's-complement signed fixed-point.
- CHANNEL, 32, number of channels packed per beat.
- IMG_WIDHT, 44, input columns (>=2).
- IMG_HEIGHT, 44, input rows (>=2).
- MODE, 0, selects the pooling function: 0 = max pool, 1 = average pool.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- Data_In  input  DATA_WIDHT*CHANNEL  input pixel; channel k occupies bits [DATA_WIDHT*(k+1)-1 : DATA_WIDHT*k].
- Valid_In  input  1  Data_In is valid this cycle (one pixel per high cycle; gaps allowed).
- Data_Out  output  DATA_WIDHT*CHANNEL  pooled pixel, same channel packing as Data_In.
- Valid_Out  output  1  Data_Out is valid; single-cycle pulse per pooled pixel.
- Frame_Done  output  1  one-cycle pulse when the last input pixel of a frame is accepted.

Behaviour:
- Interface: one clock, asynchronous active-low reset (rst=0 resets). No backpressure; a beat is accepted every cycle Valid_In=1.
- Reset values: Data_Out=0, Valid_Out=0, Frame_Done=0, col=0, row=0, FSM=EVEN_ROW. The line buffer is not reset; its contents are don't-care.
- Counters: col counts 0..IMG_WIDHT-1 and row counts 0..IMG_HEIGHT-1, advancing only on accepted beats.
  - col wraps to 0 at end of line and row increments.
  - After the final pixel (row=IMG_HEIGHT-1, col=IMG_WIDHT-1), both wrap to 0 and Frame_Done pulses the next cycle.
- Pair register: on an even col, the current pixel is stored in a per-channel pair register.
- Horizontal reduction: on an odd col, reduce(pair, current) is formed per channel.
  - MODE 0: signed max.
  - MODE 1: signed sum, DATA_WIDHT+1 bits.
- Line buffer: IMG_WIDHT/2 entries x CHANNEL x (DATA_WIDHT+1) bits, indexed col>>1.
- FSM:
  - EVEN_ROW: odd-col reductions are written into the line buffer. At end of line -> ODD_ROW.
  - ODD_ROW: odd-col reductions are combined with the buffer entry, using max, or sum to DATA_WIDHT+2 bits followed by an arithmetic shift right by 2 (floor toward -inf), truncated to DATA_WIDHT. The result is registered to Data_Out and Valid_Out=1. At end of line:
    - -> SKIP_ROW if the next row is the last row and IMG_HEIGHT is odd;
    - -> EVEN_ROW otherwise, including wrap to the next frame.
  - SKIP_ROW: beats are accepted and counted but produce no output. At end of frame -> EVEN_ROW.
- Latency: Valid_Out rises exactly 1 cycle after the beat carrying the bottom-right pixel of a window.
  - Data_Out holds its value until the next valid output.
  - Valid_Out is low in every other cycle.
- Odd IMG_WIDHT: the last column of every row is accepted but ignored; it writes nothing and emits nothing.
- Output frame: floor(IMG_WIDHT/2) x floor(IMG_HEIGHT/2) pixels, in raster order.
- Input gaps: Valid_In=0 freezes all counters, FSM state and pair register; no output is produced.
- Back-to-back frames: a new frame may start on the cycle after the last beat of the previous frame, with no idle cycle needed.
- Reset mid-frame: everything returns to its reset values immediately. The next accepted beat is treated as pixel (0,0).
- Overflow: in MODE 1 the intermediate sums are widened so no overflow occurs. In MODE 0 no overflow is possible.

Test Plan:
- MODE0, CHANNEL=2, 4x4 image, ch0=r*4+c, ch1=-(r*4+c), Valid_In held high for 16 beats -> 4 Valid_Out pulses.
  - Each pulse is 1 cycle after beats 6, 8, 14, 16.
  - ch0 = 00000005, 00000007, 0000000D, 0000000F.
  - ch1 = 00000000, FFFFFFFE, FFFFFFF8, FFFFFFF6.
  - Frame_Done pulses once, 1 cycle after beat 16.
- MODE1, same stimulus -> ch0 = 00000002, 00000004, 0000000A, 0000000C and ch1 = FFFFFFFD, FFFFFFFB, FFFFFFF5, FFFFFFF3 (floor rounding).
- MODE0, 5x5 image with ch0=r*5+c -> exactly 4 outputs 6, 8, 16, 18. Column 4 and row 4 produce nothing. Frame_Done follows beat 25.
- MODE0, 4x4 image as in scenario 1, with Valid_In deasserted for 3 cycles after every 2nd beat -> the same 4 values. Each output is 1 cycle after its window's last beat, with no spurious pulses.
- Two consecutive 4x4 frames back-to-back, the second with values +100 -> 8 outputs; the second set is 105, 107, 113, 115. Frame_Done pulses twice.
- rst pulled low after beat 7 of a frame, then a full fresh 4x4 frame is sent -> outputs are cleared while reset is held. The fresh frame yields exactly the 4 values of scenario 1, with no stale-buffer contamination.
